// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          TIMEOUT_CYCLES_DEF = 15;
    localparam logic [15:0] ERR_DATA           = 16'hFFFF;

    // Everything captured from EX/MEM when an access starts.
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        from_mem;
        logic        write_reg;
        logic [3:0]  dst_reg;
        logic [15:0] dst_data;
        logic        hlt;
    } mem_txn_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts REQ cycles; tc flags the cycle in which the LIMIT-th wait cycle is reached.
module mem_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int          W        = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !tc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the pipe around a req/ack memory access (IDLE/REQ/DONE).
// Optional abort of unanswered requests with sticky mem_err when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_Data_Mem_en,
    input  logic        in_Data_Mem_wr,
    input  logic [15:0] in_Data_Mem_Addr,
    input  logic [15:0] in_Data_Mem_In,
    input  logic        in_from_mem,
    input  logic        in_WriteReg,
    input  logic        in_hlt,
    input  logic [3:0]  in_DstReg,
    input  logic [15:0] in_DstData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_WriteReg,
    output logic [3:0]  wb_DstReg,
    output logic [15:0] wb_Data,
    output logic        wb_hlt,
    output logic        mem_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    mem_txn_t    txn_q, txn_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;

`ifdef MEM_TIMEOUT_EN
    logic err_q, err_d;
    logic to_q, to_d;
    logic tc;

    mem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state_q != REQ),
        .en  (state_q == REQ),
        .tc  (tc)
    );

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;

    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        rdata_d   = rdata_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
`ifdef MEM_TIMEOUT_EN
        err_d     = err_q;
        to_d      = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_Data_Mem_en) begin
                    state_d   = REQ;
                    txn_d     = '{wr:        in_Data_Mem_wr,
                                  addr:      in_Data_Mem_Addr,
                                  wdata:     in_Data_Mem_In,
                                  from_mem:  in_from_mem,
                                  write_reg: in_WriteReg,
                                  dst_reg:   in_DstReg,
                                  dst_data:  in_DstData,
                                  hlt:       in_hlt};
                    mem_req_d = 1'b1;
                    mem_we_d  = in_Data_Mem_wr;
`ifdef MEM_TIMEOUT_EN
                    to_d      = 1'b0;
`endif
                end
            end
            REQ: begin
                // An ack in the terminal-count cycle still completes normally.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!txn_q.wr)
                        rdata_d = mem_rdata;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tc) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    to_d      = 1'b1;
                    err_d     = 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            txn_q     <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_q     <= 1'b0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            txn_q     <= txn_d;
            rdata_q   <= rdata_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
`ifdef MEM_TIMEOUT_EN
            err_q     <= err_d;
            to_q      <= to_d;
`endif
        end
    end

    // Pass-through is the default; reset forces it so a held request cannot stall the pipe.
    always_comb begin
        stall       = 1'b0;
        wb_WriteReg = in_WriteReg;
        wb_DstReg   = in_DstReg;
        wb_Data     = in_DstData;
        wb_hlt      = in_hlt;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (in_Data_Mem_en) begin
                        stall       = 1'b1;
                        wb_WriteReg = 1'b0;
                        wb_hlt      = 1'b0;
                    end
                end
                REQ: begin
                    stall       = 1'b1;
                    wb_WriteReg = 1'b0;
                    wb_hlt      = 1'b0;
                end
                DONE: begin
                    wb_WriteReg = txn_q.write_reg;
                    wb_DstReg   = txn_q.dst_reg;
                    wb_Data     = txn_q.from_mem ? rdata_q : txn_q.dst_data;
                    wb_hlt      = txn_q.hlt;
`ifdef MEM_TIMEOUT_EN
                    if (to_q) begin
                        wb_WriteReg = 1'b0;
                        wb_Data     = ERR_DATA;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised bench for mem_stage_ctrl against a transaction-level model, plus directed literal checks.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_Data_Mem_en = 1'b0, in_Data_Mem_wr = 1'b0;
    logic [15:0] in_Data_Mem_Addr = '0, in_Data_Mem_In = '0;
    logic        in_from_mem = 1'b0, in_WriteReg = 1'b0, in_hlt = 1'b0;
    logic [3:0]  in_DstReg = '0;
    logic [15:0] in_DstData = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        stall, wb_WriteReg, wb_hlt, mem_err;
    logic [3:0]  wb_DstReg;
    logic [15:0] wb_Data;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_Data_Mem_en(in_Data_Mem_en), .in_Data_Mem_wr(in_Data_Mem_wr),
        .in_Data_Mem_Addr(in_Data_Mem_Addr), .in_Data_Mem_In(in_Data_Mem_In),
        .in_from_mem(in_from_mem), .in_WriteReg(in_WriteReg), .in_hlt(in_hlt),
        .in_DstReg(in_DstReg), .in_DstData(in_DstData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_WriteReg(wb_WriteReg), .wb_DstReg(wb_DstReg),
        .wb_Data(wb_Data), .wb_hlt(wb_hlt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          wr;
        logic [15:0] addr, wdata;
        bit          fm, wreg;
        logic [3:0]  dst;
        logic [15:0] dd;
        bit          hlt;
    } txn_t;

    bit          m_busy, m_done, m_to, m_err;
    int          m_wait;
    txn_t        m_t;
    logic [15:0] m_rdata;
`ifdef MEM_TIMEOUT_EN
    localparam bit M_TO_EN = 1'b1;
`else
    localparam bit M_TO_EN = 1'b0;
`endif

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_to = 0; m_err = 0; m_wait = 0;
        m_t = '{wr: 0, addr: '0, wdata: '0, fm: 0, wreg: 0, dst: '0, dd: '0, hlt: 0};
        m_rdata = '0;
    endtask

    // Compare every output against the model; called mid-cycle after inputs settle.
    task automatic sample();
        bit stall_in;
        #1;
        if (!rst) model_reset();
        chk1("mem_err", mem_err, m_err);
        if (!rst || (!m_busy && !m_done)) begin
            stall_in = rst && in_Data_Mem_en;
            chk1("idle_mem_req", mem_req, 1'b0);
            chk1("idle_mem_we", mem_we, 1'b0);
            if (!rst) begin
                chk16("rst_mem_addr", mem_addr, 16'h0);
                chk16("rst_mem_wdata", mem_wdata, 16'h0);
            end
            chk1("idle_stall", stall, stall_in);
            chk1("idle_wb_wreg", wb_WriteReg, stall_in ? 1'b0 : in_WriteReg);
            chk1("idle_wb_hlt", wb_hlt, stall_in ? 1'b0 : in_hlt);
            if (!stall_in) begin
                chk16("idle_wb_dst", 16'(wb_DstReg), 16'(in_DstReg));
                chk16("idle_wb_data", wb_Data, in_DstData);
            end
        end else if (m_busy) begin
            chk1("req_mem_req", mem_req, 1'b1);
            chk1("req_mem_we", mem_we, m_t.wr);
            chk16("req_mem_addr", mem_addr, m_t.addr);
            chk16("req_mem_wdata", mem_wdata, m_t.wdata);
            chk1("req_stall", stall, 1'b1);
            chk1("req_wb_wreg", wb_WriteReg, 1'b0);
            chk1("req_wb_hlt", wb_hlt, 1'b0);
        end else begin
            chk1("done_mem_req", mem_req, 1'b0);
            chk1("done_mem_we", mem_we, 1'b0);
            chk1("done_stall", stall, 1'b0);
            chk1("done_wb_wreg", wb_WriteReg, m_to ? 1'b0 : m_t.wreg);
            chk16("done_wb_dst", 16'(wb_DstReg), 16'(m_t.dst));
            chk16("done_wb_data", wb_Data,
                  m_to ? 16'hFFFF : (m_t.fm ? m_rdata : m_t.dd));
            chk1("done_wb_hlt", wb_hlt, m_t.hlt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                m_wait++;
                if (mem_ack) begin
                    if (!m_t.wr) m_rdata = mem_rdata;
                    m_busy = 0; m_done = 1; m_to = 0;
                end else if (M_TO_EN && m_wait == TO) begin
                    m_busy = 0; m_done = 1; m_to = 1; m_err = 1;
                end
            end else if (in_Data_Mem_en) begin
                m_t = '{wr: in_Data_Mem_wr, addr: in_Data_Mem_Addr, wdata: in_Data_Mem_In,
                        fm: in_from_mem, wreg: in_WriteReg, dst: in_DstReg,
                        dd: in_DstData, hlt: in_hlt};
                m_busy = 1; m_wait = 0;
            end
        end
    endtask

    task automatic drive(input bit en, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input bit fm, input bit wreg,
                         input logic [3:0] dst, input logic [15:0] dd, input bit hlt);
        in_Data_Mem_en = en; in_Data_Mem_wr = wr; in_Data_Mem_Addr = addr;
        in_Data_Mem_In = wd; in_from_mem = fm; in_WriteReg = wreg;
        in_DstReg = dst; in_DstData = dd; in_hlt = hlt;
    endtask

    task automatic mem(input bit ack, input logic [15:0] rd);
        mem_ack = ack; mem_rdata = rd;
    endtask

    int st;

    initial begin
        model_reset();

        // Reset: stall gated off, pass-through, bus cleared.
        @(negedge clk); drive(1, 0, 16'h1111, 16'h2222, 1, 1, 4'h9, 16'h9999, 1); mem(0, 0);
        sample();
        chk1("lit_rst_stall", stall, 1'b0);
        chk1("lit_rst_mem_req", mem_req, 1'b0);
        chk16("lit_rst_mem_addr", mem_addr, 16'h0);
        chk1("lit_rst_mem_err", mem_err, 1'b0);
        chk1("lit_rst_wb_wreg", wb_WriteReg, 1'b1);
        step();

        // ALU op.
        @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 1, 4'h3, 16'h1234, 0);
        sample();
        chk1("lit_alu_wreg", wb_WriteReg, 1'b1);
        chk16("lit_alu_dst", 16'(wb_DstReg), 16'h3);
        chk16("lit_alu_data", wb_Data, 16'h1234);
        chk1("lit_alu_stall", stall, 1'b0);
        chk1("lit_alu_req", mem_req, 1'b0);
        step();

        // Load, ack on third REQ cycle.
        @(negedge clk); drive(1, 0, 16'h0040, 0, 1, 1, 4'h5, 16'h7777, 0);
        sample(); st = int'(stall);
        chk1("lit_ld_entry_wreg", wb_WriteReg, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mem(i == 2, 16'hBEEF);
            sample(); st += int'(stall);
            chk1("lit_ld_req", mem_req, 1'b1);
            chk16("lit_ld_addr", mem_addr, 16'h0040);
            step();
        end
        @(negedge clk); mem(0, 0);
        sample();
        chk16("lit_ld_data", wb_Data, 16'hBEEF);
        chk1("lit_ld_wreg", wb_WriteReg, 1'b1);
        chk1("lit_ld_done_stall", stall, 1'b0);
        chk16("lit_ld_stall_cycles", 16'(st), 16'd4);
        step();

        // Store, ack in first REQ cycle.
        @(negedge clk); drive(1, 1, 16'h0010, 16'hA5A5, 0, 0, 4'h2, 0, 0);
        sample(); st = int'(stall);
        step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mem(1, 16'h3333);
        sample(); st += int'(stall);
        chk1("lit_st_we", mem_we, 1'b1);
        chk16("lit_st_wdata", mem_wdata, 16'hA5A5);
        step();
        @(negedge clk); mem(0, 0);
        sample();
        chk1("lit_st_we_off", mem_we, 1'b0);
        chk1("lit_st_wreg", wb_WriteReg, 1'b0);
        chk16("lit_st_stall_cycles", 16'(st), 16'd2);
        step();

        // Reset in second REQ cycle.
        @(negedge clk); drive(1, 0, 16'h0020, 0, 1, 1, 4'h6, 0, 0);
        sample(); step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); step();
        @(negedge clk); rst = 1'b0;
        sample();
        chk1("lit_rst_req_drop", mem_req, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rst = 1'b1;
            sample();
            chk1("lit_rst_no_wb", wb_WriteReg, 1'b0);
            chk1("lit_rst_no_req", mem_req, 1'b0);
            step();
        end

        // Spurious ack in IDLE, then a from_mem store shows rdata untouched.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem(1, 16'h1111);
            sample();
            chk1("lit_spur_req", mem_req, 1'b0);
            chk1("lit_spur_stall", stall, 1'b0);
            step();
        end
        @(negedge clk); drive(1, 1, 16'h0030, 16'h0055, 1, 1, 4'h7, 0, 0); mem(0, 0);
        sample(); step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mem(1, 16'h2222);
        sample(); step();
        @(negedge clk); mem(0, 0);
        sample();
        chk16("lit_spur_rdata", wb_Data, 16'h0000);
        chk1("lit_spur_wreg", wb_WriteReg, 1'b1);
        step();

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TO REQ cycles.
        @(negedge clk); drive(1, 0, 16'h0050, 0, 1, 1, 4'h8, 0, 0);
        sample(); step();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mem(0, 0);
            sample();
            chk1("lit_to_req", mem_req, 1'b1);
            step();
        end
        @(negedge clk);
        sample();
        chk16("lit_to_data", wb_Data, 16'hFFFF);
        chk1("lit_to_wreg", wb_WriteReg, 1'b0);
        chk1("lit_to_err", mem_err, 1'b1);
        step();
        @(negedge clk);
        sample();
        chk1("lit_to_err_sticky", mem_err, 1'b1);
        step();
        @(negedge clk); rst = 1'b0;
        sample();
        chk1("lit_to_err_clr", mem_err, 1'b0);
        step();
        @(negedge clk); rst = 1'b1;
        sample(); step();
`else
        // No ack: request waits indefinitely.
        @(negedge clk); drive(1, 0, 16'h0050, 0, 1, 1, 4'h8, 0, 0);
        sample(); step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mem(0, 0);
            sample(); step();
        end
        @(negedge clk);
        sample();
        chk1("lit_wait_req", mem_req, 1'b1);
        chk1("lit_wait_err", mem_err, 1'b0);
        step();
        @(negedge clk); mem(1, 16'hC0DE);
        sample(); step();
        @(negedge clk); mem(0, 0);
        sample();
        chk16("lit_wait_data", wb_Data, 16'hC0DE);
        step();
`endif

        // Random traffic, including spurious acks, ignored inputs and reset pulses.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 79) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
            mem($urandom_range(0, 2) == 0, 16'($urandom));
            sample();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: REQ-state cycles without mem_ack before abort; used only with MEM_TIMEOUT_EN.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_Data_Mem_en  in  1  EX/MEM: memory access requested.
REQ-005 in_Data_Mem_wr  in  1  EX/MEM: 1 = store, 0 = load.
REQ-006 in_Data_Mem_Addr  in  16  EX/MEM: byte address.
REQ-007 in_Data_Mem_In  in  16  EX/MEM: store data.
REQ-008 in_from_mem, in_WriteReg, in_hlt  in  1 each  EX/MEM control bits.
REQ-009 in_DstReg  in  4;  in_DstData  in  16  EX/MEM destination register and ALU result.
REQ-010 mem_req  out  1;  mem_we  out  1;  mem_addr  out  16;  mem_wdata  out  16  memory request bus.
REQ-011 mem_ack  in  1;  mem_rdata  in  16  memory completion and load data, valid together.
REQ-012 stall  out  1  1 = hold EX/MEM and upstream (drives exmem_en low).
REQ-013 wb_WriteReg  out  1;  wb_DstReg  out  4;  wb_Data  out  16;  wb_hlt  out  1  to MEM/WB register.
REQ-014 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-015 FSM states IDLE, REQ, DONE; IDLE after reset.
REQ-016 IDLE, in_Data_Mem_en=0: wb_* equal in_WriteReg/in_DstReg/in_DstData/in_hlt combinationally, stall=0, zero latency.
REQ-017 IDLE, in_Data_Mem_en=1: stall=1 and wb_WriteReg=0, wb_hlt=0 that cycle; latch wr, addr, wdata, from_mem, WriteReg, DstReg, DstData, hlt; next state REQ.
REQ-018 REQ: mem_req=1; mem_we, mem_addr, mem_wdata from latched values, held stable until ack; stall=1; wb_WriteReg=0, wb_hlt=0.
REQ-019 REQ with mem_ack=1: capture mem_rdata when latched wr=0; next state DONE; mem_req drops the following cycle.
REQ-020 DONE: stall=0; wb_DstReg, wb_hlt from latch; wb_WriteReg = latched WriteReg; wb_Data = captured rdata if latched from_mem=1, else latched DstData; next state IDLE unconditionally.
REQ-021 Minimum access = 3 cycles (IDLE, REQ with same-cycle ack, DONE); each extra ack-wait cycle adds one.
REQ-022 mem_ack outside REQ is ignored; mem_req never 1 outside REQ.
REQ-023 EX/MEM inputs are ignored in REQ and DONE; upstream holds them via stall.
REQ-024 Stores set wb_WriteReg = latched WriteReg unchanged; rdata not captured.

Reset
REQ-025 rst low: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all latches=0, mem_err=0, timeout counter=0, immediately and asynchronously.
REQ-026 Reset during REQ or DONE abandons the access; no wb_WriteReg pulse follows.
REQ-027 With rst low, stall=0 and wb_* equal their IDLE pass-through values.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN defined: counter runs in REQ and clears on REQ entry; reaching TIMEOUT_CYCLES without ack gives next state DONE, mem_err=1 (sticky until reset), wb_WriteReg=0 in that DONE, wb_Data=16'hFFFF.
REQ-029 Ack on the same cycle as the timeout count is reached wins; the access completes normally and mem_err stays unchanged.
REQ-030 Macro undefined: REQ waits indefinitely; mem_err tied 0; port remains; no counter logic.

Structure
REQ-031 Package mem_stage_pkg holds the state enum (IDLE/REQ/DONE), default TIMEOUT_CYCLES, and the 16'hFFFF error constant.
REQ-032 One sub-module, mem_timeout_cnt (clear, enable, terminal count), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-033 ALU op: in_Data_Mem_en=0, WriteReg=1, DstReg=4'h3, DstData=16'h1234 -> same cycle wb_WriteReg=1, wb_DstReg=3, wb_Data=16'h1234, stall=0, mem_req=0.
REQ-034 Load addr 16'h0040, memory acks 2 cycles after mem_req with rdata 16'hBEEF -> stall high 4 cycles; DONE shows wb_Data=16'hBEEF, wb_WriteReg=1.
REQ-035 Store addr 16'h0010, data 16'hA5A5, ack in first REQ cycle -> mem_we=1, mem_wdata=16'hA5A5 for one cycle; stall high 2 cycles; wb_WriteReg=0 when in_WriteReg=0.
REQ-036 rst low in second REQ cycle -> mem_req=0 at once; after release state IDLE, no wb_WriteReg pulse.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then DONE with wb_Data=16'hFFFF, wb_WriteReg=0, mem_err=1 held until reset.
REQ-038 Spurious mem_ack=1 in IDLE with in_Data_Mem_en=0 -> no state change, no rdata capture.
